// File: rtl/demux_stream_1xn_if.sv
`default_nettype none
//==============================================================================
// Module      : demux_stream_1xn_if
// Description : Stream bundle for the 1-to-N packet demux: one ingress port
//               plus NUM_OUT packed egress lanes.
// Revision    : 1.0 - initial release
//==============================================================================
interface demux_stream_1xn_if #(
   parameter int DATA_W  = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = 2
);
   logic                      s_valid;
   logic                      s_ready;
   logic [DATA_W-1:0]         s_data;
   logic                      s_last;
   logic [SEL_W-1:0]          s_sel;
   logic                      s_bcast;
   logic [NUM_OUT-1:0]        m_valid;
   logic [NUM_OUT-1:0]        m_ready;
   logic [NUM_OUT*DATA_W-1:0] m_data;
   logic [NUM_OUT-1:0]        m_last;

   // slave: the demux itself; master: the ingress producer / lane consumers
   modport slave (
      input  s_valid, s_data, s_last, s_sel, s_bcast, m_ready,
      output s_ready, m_valid, m_data, m_last
   );
   modport master (
      output s_valid, s_data, s_last, s_sel, s_bcast, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );
endinterface
`default_nettype wire

// File: rtl/demux_stream_1xn.sv
`default_nettype none
//==============================================================================
// Module      : demux_stream_1xn
// Description : Registered 1-to-N packet demultiplexer with valid/ready on
//               every port. Optional broadcast mode under macro DEMUX_BCAST_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module demux_stream_1xn #(
   parameter int DATA_W  = 8,
   parameter int NUM_OUT = 4,
   parameter int SEL_W   = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   demux_stream_1xn_if.slave strm,
   output logic              busy,
   output logic              err_sel
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUTE = 2'd1,
      S_DROP  = 2'd2,
      S_BCAST = 2'd3
   } state_t;

   localparam int unsigned c_num_out = NUM_OUT;

   state_t                    r_state;
   logic [SEL_W-1:0]          r_ch;
   logic                      r_obuf_valid;
   logic [DATA_W-1:0]         r_obuf_data;
   logic                      r_obuf_last;
   logic                      r_err_sel;

   logic [NUM_OUT-1:0]        w_lane_hit;
   logic [NUM_OUT-1:0]        w_m_valid;
   logic [NUM_OUT-1:0]        w_m_last;
   logic [NUM_OUT*DATA_W-1:0] w_m_data;
   logic                      w_ch_ready;
   logic                      w_drain;
   logic                      w_s_ready;
   logic                      w_accept;
   logic                      w_first;
   logic                      w_sel_bad;
   logic                      w_start_bcast;
   logic                      w_load;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_lane
         assign w_lane_hit[gi]                    = (r_ch == SEL_W'(gi));
         assign w_m_data[gi*DATA_W +: DATA_W]     = w_m_valid[gi] ? r_obuf_data : '0;
         assign w_m_last[gi]                      = w_m_valid[gi] & r_obuf_last;
      end
   endgenerate

   // Decode-and-reduce instead of m_ready[r_ch] so a latched bad select never indexes out of range
   assign w_ch_ready = |(w_lane_hit & strm.m_ready);
   assign w_sel_bad  = (32'(strm.s_sel) >= c_num_out);
   assign w_first    = w_accept && (r_state == S_IDLE);

`ifdef DEMUX_BCAST_EN
   logic               r_obuf_bcast;
   logic [NUM_OUT-1:0] r_done;
   logic               w_bcast_retire;

   assign w_start_bcast  = w_first && strm.s_bcast;
   assign w_bcast_retire = &(r_done | strm.m_ready);
   assign w_drain        = r_obuf_valid && (r_obuf_bcast ? w_bcast_retire : w_ch_ready);
   assign w_m_valid      = {NUM_OUT{r_obuf_valid}} &
                           (r_obuf_bcast ? ~r_done : w_lane_hit);

   // Done mask restarts whenever the buffer retires or reloads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_obuf_bcast <= 1'b0;
         r_done       <= '0;
      end else begin
         if (w_load) begin
            r_obuf_bcast <= (r_state == S_BCAST) || w_start_bcast;
         end
         if (w_load || w_drain) begin
            r_done <= '0;
         end else if (r_obuf_valid && r_obuf_bcast) begin
            r_done <= r_done | strm.m_ready;
         end
      end
   end
`else
   logic w_unused_bcast;

   assign w_unused_bcast = strm.s_bcast;
   assign w_start_bcast  = 1'b0;
   assign w_drain        = r_obuf_valid && w_ch_ready;
   assign w_m_valid      = {NUM_OUT{r_obuf_valid}} & w_lane_hit;
`endif

   assign w_s_ready = (r_state == S_DROP) || !r_obuf_valid || w_drain;
   assign w_accept  = strm.s_valid && w_s_ready;

   // A bad-select first beat is discarded; DROP beats never touch the buffer
   assign w_load = w_accept &&
                   ((r_state == S_ROUTE) || (r_state == S_BCAST) ||
                    ((r_state == S_IDLE) && (w_start_bcast || !w_sel_bad)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ch         <= '0;
         r_obuf_valid <= 1'b0;
         r_obuf_data  <= '0;
         r_obuf_last  <= 1'b0;
         r_err_sel    <= 1'b0;
      end else begin
         r_err_sel <= 1'b0;

         if (w_load) begin
            r_obuf_valid <= 1'b1;
            r_obuf_data  <= strm.s_data;
            r_obuf_last  <= strm.s_last;
         end else if (w_drain) begin
            r_obuf_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ch <= strm.s_sel;
                  if (w_start_bcast) begin
                     r_state <= strm.s_last ? S_IDLE : S_BCAST;
                  end else if (w_sel_bad) begin
                     r_err_sel <= 1'b1;
                     r_state   <= strm.s_last ? S_IDLE : S_DROP;
                  end else begin
                     r_state <= strm.s_last ? S_IDLE : S_ROUTE;
                  end
               end
            end
            S_ROUTE, S_DROP, S_BCAST: begin
               if (w_accept && strm.s_last) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign strm.s_ready = w_s_ready;
   assign strm.m_valid = w_m_valid;
   assign strm.m_data  = w_m_data;
   assign strm.m_last  = w_m_last;
   assign busy         = (r_state != S_IDLE);
   assign err_sel      = r_err_sel;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream_1xn.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_demux_stream_1xn
// Description : Scoreboard bench for demux_stream_1xn (4-lane main DUT plus a
//               3-lane instance for out-of-range selects).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_demux_stream_1xn;
   localparam int NUM_OUT = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy, err_sel, busy3, err_sel3;

   always #5 clk = ~clk;

   demux_stream_1xn_if #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) ifc  ();
   demux_stream_1xn_if #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) ifc3 ();

   demux_stream_1xn #(.DATA_W(8), .NUM_OUT(4), .SEL_W(2)) dut (
      .clk(clk), .rst(rst), .strm(ifc), .busy(busy), .err_sel(err_sel)
   );
   demux_stream_1xn #(.DATA_W(8), .NUM_OUT(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst), .strm(ifc3), .busy(busy3), .err_sel(err_sel3)
   );

   int    total = 0;
   int    bad   = 0;
   int    err3_cnt = 0;
   int    mv3_cnt  = 0;
   beat_t exp_q [NUM_OUT][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops a lane's expected beat whenever that lane handshakes
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (ifc.m_valid[i] && ifc.m_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_beat lane%0d: got data %0h, expected no beat",
                           i, ifc.m_data[i*8 +: 8]);
               end else begin
                  beat_t e;
                  e = exp_q[i].pop_front();
                  chk($sformatf("lane%0d_data", i), 32'(ifc.m_data[i*8 +: 8]), 32'(e.data));
                  chk($sformatf("lane%0d_last", i), 32'(ifc.m_last[i]), 32'(e.last));
               end
            end else if (!ifc.m_valid[i]) begin
               chk($sformatf("lane%0d_idle_zero", i),
                   32'({ifc.m_last[i], ifc.m_data[i*8 +: 8]}), 32'(0));
            end
         end
         if (err_sel3)       err3_cnt++;
         if (|ifc3.m_valid)  mv3_cnt++;
      end
   end

   task automatic send(input logic [1:0] sel, input logic [7:0] data, input logic last,
                       input logic bc, output int stalls);
      beat_t b;
      ifc.s_valid = 1'b1;
      ifc.s_sel   = sel;
      ifc.s_data  = data;
      ifc.s_last  = last;
      ifc.s_bcast = bc;
      stalls      = 0;
      b.data      = data;
      b.last      = last;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (ifc.s_ready) begin
            @(posedge clk);
            if (bc) begin
               for (int i = 0; i < NUM_OUT; i++) exp_q[i].push_back(b);
            end else begin
               exp_q[sel].push_back(b);
            end
            #1;
            return;
         end
         stalls++;
         @(posedge clk);
         #1;
      end
      total++;
      bad++;
      $display("FAIL send_timeout: beat %0h not accepted within 50 cycles", data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, stt;
      ifc.s_valid  = 1'b0; ifc.s_sel  = '0; ifc.s_data  = '0; ifc.s_last  = 1'b0;
      ifc.s_bcast  = 1'b0; ifc.m_ready = 4'hF;
      ifc3.s_valid = 1'b0; ifc3.s_sel = '0; ifc3.s_data = '0; ifc3.s_last = 1'b0;
      ifc3.s_bcast = 1'b0; ifc3.m_ready = 3'h7;

      // Reset
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_m_valid", 32'(ifc.m_valid), 32'(0));
      chk("rst_m_data",  32'(ifc.m_data),  32'(0));
      chk("rst_s_ready", 32'(ifc.s_ready), 32'(1));
      chk("rst_busy",    32'(busy),        32'(0));
      chk("rst_err_sel", 32'(err_sel),     32'(0));
      @(posedge clk); #1;

      // Single-beat packets to every lane, back to back
      stt = 0;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] d;
         d = 8'hA0 + 8'(i);
         send(2'(i), d, 1'b1, 1'b0, st);
         stt += st;
         chk("t2_onehot_valid", 32'(ifc.m_valid), 32'(4'b0001 << i));
         chk("t2_next_cycle_data", 32'(ifc.m_data[i*8 +: 8]), 32'(d));
      end
      ifc.s_valid = 1'b0;
      chk("t2_no_bubble", 32'(stt), 32'(0));
      repeat (2) @(posedge clk); #1;

      // Backpressure on lane 2 for 5 cycles
      ifc.m_ready = 4'b1011;
      send(2'd2, 8'hB0, 1'b0, 1'b0, st);
      ifc.s_data = 8'hB1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("t3_s_ready_low",  32'(ifc.s_ready),        32'(0));
         chk("t3_hold_valid",   32'(ifc.m_valid),        32'(4'b0100));
         chk("t3_hold_data",    32'(ifc.m_data[23:16]),  32'(8'hB0));
         chk("t3_busy",         32'(busy),               32'(1));
         @(posedge clk); #1;
      end
      ifc.m_ready = 4'hF;
      send(2'd2, 8'hB1, 1'b0, 1'b0, st);
      send(2'd2, 8'hB2, 1'b1, 1'b0, st);
      ifc.s_valid = 1'b0;
      chk("t3_busy_end", 32'(busy), 32'(0));
      repeat (3) @(posedge clk); #1;

      // Out-of-range select on the 3-lane instance
      ifc3.s_valid = 1'b1; ifc3.s_sel = 2'd3; ifc3.s_data = 8'hE0; ifc3.s_last = 1'b0;
      @(negedge clk);
      chk("t4_s_ready_b0", 32'(ifc3.s_ready), 32'(1));
      @(posedge clk); #1;
      chk("t4_err_pulse", 32'(err_sel3), 32'(1));
      chk("t4_busy_drop", 32'(busy3),    32'(1));
      ifc3.s_data = 8'hE1; ifc3.s_last = 1'b1;
      @(negedge clk);
      chk("t4_s_ready_b1", 32'(ifc3.s_ready), 32'(1));
      @(posedge clk); #1;
      chk("t4_err_single", 32'(err_sel3), 32'(0));
      chk("t4_busy_end",   32'(busy3),    32'(0));
      ifc3.s_valid = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("t4_err_count",  32'(err3_cnt), 32'(1));
      chk("t4_no_m_valid", 32'(mv3_cnt),  32'(0));

      // Reset in the middle of a packet to lane 1
      ifc.m_ready = 4'b1101;
      send(2'd1, 8'hC0, 1'b0, 1'b0, st);
      ifc.s_data = 8'hC1;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NUM_OUT; i++) exp_q[i].delete();
      #1;
      chk("t5_rst_m_valid", 32'(ifc.m_valid), 32'(0));
      chk("t5_rst_m_data",  32'(ifc.m_data),  32'(0));
      chk("t5_rst_m_last",  32'(ifc.m_last),  32'(0));
      chk("t5_rst_busy",    32'(busy),        32'(0));
      ifc.s_valid = 1'b0;
      ifc.m_ready = 4'hF;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      send(2'd0, 8'h5A, 1'b1, 1'b0, st);
      ifc.s_valid = 1'b0;
      chk("t5_route_ch0", 32'(ifc.m_valid),     32'(4'b0001));
      chk("t5_data_ch0",  32'(ifc.m_data[7:0]), 32'(8'h5A));
      repeat (2) @(posedge clk); #1;

`ifdef DEMUX_BCAST_EN
      // Broadcast with lane 1 late by 3 cycles
      ifc.m_ready = 4'b1101;
      send(2'd1, 8'hD0, 1'b0, 1'b1, st);
      fork
         send(2'd1, 8'hD1, 1'b1, 1'b1, stt);
         begin
            repeat (3) @(posedge clk);
            #1 ifc.m_ready = 4'hF;
         end
      join
      ifc.s_valid = 1'b0;
      chk("t6_retire_wait", 32'(stt), 32'(3));
      repeat (3) @(posedge clk); #1;
`endif

      repeat (4) @(posedge clk); #1;
      for (int i = 0; i < NUM_OUT; i++)
         chk($sformatf("lane%0d_queue_drained", i), 32'(exp_q[i].size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
